// File: rtl/pride_stripe_renderer.sv
// rtl/pride_stripe_renderer.sv - horizontally striped pride-flag pixel stage behind the VGA sync generator
// Optional colour rotation across frames is enabled by defining PRIDE_SCROLL_EN.
module pride_stripe_renderer #(
  parameter int H_DISPLAY     = 640,
  parameter int V_DISPLAY     = 480,
  parameter int SCROLL_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] flag_sel,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    FLAG_RAINBOW = 2'd0,
    FLAG_TRANS   = 2'd1,
    FLAG_BI      = 2'd2,
    FLAG_NB      = 2'd3
  } flag_e;

  localparam logic [9:0] H_SIX   = 10'(V_DISPLAY / 6);
  localparam logic [9:0] H_FIVE  = 10'(V_DISPLAY / 5);
  localparam logic [9:0] H_FOUR  = 10'(V_DISPLAY / 4);
  localparam logic [9:0] H_EVENT = 10'(H_DISPLAY);
  localparam logic [9:0] V_LAST  = 10'(V_DISPLAY - 1);

  flag_e      flag_q, flag_d;
  logic [2:0] stripe_q, stripe_d;
  logic [9:0] line_cnt_q, line_cnt_d;
  logic [2:0] base_next;
  logic       line_evt, frame_evt;

  logic [5:0] pix_d, pix1_q, pix2_q;
  logic       de1_q, hs1_q, vs1_q, hs2_q, vs2_q, tick_q;

  function automatic logic [2:0] stripes(flag_e f);
    case (f)
      FLAG_RAINBOW: stripes = 3'd6;
      FLAG_NB:      stripes = 3'd4;
      default:      stripes = 3'd5;
    endcase
  endfunction

  function automatic logic [9:0] height(flag_e f);
    case (f)
      FLAG_RAINBOW: height = H_SIX;
      FLAG_NB:      height = H_FOUR;
      default:      height = H_FIVE;
    endcase
  endfunction

  // Packed as {R[1:0], G[1:0], B[1:0]}.
  function automatic logic [5:0] colour(flag_e f, logic [2:0] s);
    logic [5:0] c;
    c = 6'h00;
    case (f)
      FLAG_RAINBOW:
        case (s)
          3'd0: c = 6'h30;
          3'd1: c = 6'h34;
          3'd2: c = 6'h3C;
          3'd3: c = 6'h08;
          3'd4: c = 6'h03;
          3'd5: c = 6'h22;
          default: c = 6'h00;
        endcase
      FLAG_TRANS:
        case (s)
          3'd0, 3'd4: c = 6'h1B;
          3'd1, 3'd3: c = 6'h3A;
          3'd2:       c = 6'h3F;
          default:    c = 6'h00;
        endcase
      FLAG_BI:
        case (s)
          3'd0, 3'd1: c = 6'h31;
          3'd2:       c = 6'h22;
          3'd3, 3'd4: c = 6'h02;
          default:    c = 6'h00;
        endcase
      default:
        case (s)
          3'd0:    c = 6'h3C;
          3'd1:    c = 6'h3F;
          3'd2:    c = 6'h27;
          default: c = 6'h00;
        endcase
    endcase
    return c;
  endfunction

  assign line_evt  = (hpos == H_EVENT) && (vpos < V_LAST);
  assign frame_evt = (hpos == H_EVENT) && (vpos == V_LAST);

`ifdef PRIDE_SCROLL_EN
  localparam int FC_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(SCROLL_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]      base_q, base_d;

  // A flag change restarts the rotation so the new flag opens on its first stripe.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    base_d      = base_q;
    if (frame_evt) begin
      if (flag_e'(flag_sel) != flag_q) begin
        frame_cnt_d = '0;
        base_d      = 3'd0;
      end else if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        base_d      = (base_q == stripes(flag_q) - 3'd1) ? 3'd0 : base_q + 3'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      base_q      <= 3'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      base_q      <= base_d;
    end
  end

  assign base_next = base_d;
`else
  assign base_next = 3'd0;
`endif

  // Stripe only moves at hpos==H_DISPLAY, so it never changes inside a visible span.
  always_comb begin
    flag_d     = flag_q;
    stripe_d   = stripe_q;
    line_cnt_d = line_cnt_q;
    if (frame_evt) begin
      flag_d     = flag_e'(flag_sel);
      line_cnt_d = 10'd0;
      stripe_d   = base_next;
    end else if (line_evt) begin
      if (line_cnt_q == height(flag_q) - 10'd1) begin
        line_cnt_d = 10'd0;
        stripe_d   = (stripe_q == stripes(flag_q) - 3'd1) ? 3'd0 : stripe_q + 3'd1;
      end else begin
        line_cnt_d = line_cnt_q + 10'd1;
      end
    end
  end

  assign pix_d = colour(flag_q, stripe_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q     <= FLAG_RAINBOW;
      stripe_q   <= 3'd0;
      line_cnt_q <= 10'd0;
      pix1_q     <= 6'h00;
      de1_q      <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      pix2_q     <= 6'h00;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      flag_q     <= flag_d;
      stripe_q   <= stripe_d;
      line_cnt_q <= line_cnt_d;
      pix1_q     <= pix_d;
      de1_q      <= display_on;
      hs1_q      <= hsync_in;
      vs1_q      <= vsync_in;
      pix2_q     <= de1_q ? pix1_q : 6'h00;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      tick_q     <= frame_evt;
    end
  end

  assign r          = pix2_q[5:4];
  assign g          = pix2_q[3:2];
  assign b          = pix2_q[1:0];
  assign hsync_out  = hs2_q;
  assign vsync_out  = vs2_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_pride_stripe_renderer.sv
// tb/tb_pride_stripe_renderer.sv - randomized self-checking bench for pride_stripe_renderer
// Compressed raster: each line is a few random visible pixels, the hpos==640 event and one blank pixel.
module tb_pride_stripe_renderer;
  localparam int HD = 640, VD = 480, HT = 800, VT = 525, SF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in;
  logic [1:0] flag_sel;
  logic       hsync_out, vsync_out, frame_tick;
  logic [1:0] r, g, b;

  int n_checks = 0, n_fail = 0;

  pride_stripe_renderer #(.H_DISPLAY(HD), .V_DISPLAY(VD), .SCROLL_FRAMES(SF)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .flag_sel(flag_sel),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .r(r), .g(g), .b(b), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [5:0] pal [4][6];
  int         nstr [4];
  int         hgt [4];
  logic [5:0] obs [VD];

  int         frame_flag, frame_idx;
  logic [5:0] s1_rgb;
  logic       s1_hs, s1_vs, s1_de;
  int         s1_v;
  int         bad_rgb, bad_sync, bad_ft, blank_nz, ft_seen;
  int         last_v;
  logic [5:0] last_got, last_want;

  function automatic logic [5:0] c(int rr, int gg, int bb);
    return {2'(rr), 2'(gg), 2'(bb)};
  endfunction

  task automatic model_reset();
    frame_flag = 0; frame_idx = 0;
    s1_rgb = '0; s1_hs = 1'b0; s1_vs = 1'b0; s1_de = 1'b0; s1_v = 0;
  endtask

  task automatic clear_stats();
    bad_rgb = 0; bad_sync = 0; bad_ft = 0; blank_nz = 0; ft_seen = 0;
    for (int v = 0; v < VD; v++) obs[v] = 'x;
  endtask

  // One pixel clock: drive, advance to the next negedge, compare against the reference.
  task automatic tick(input int h, input int v);
    logic [5:0] cur;
    logic       de, fe;
    int         s, base;
    de = (h < HD) && (v < VD);
    hpos = 10'(h); vpos = 10'(v); display_on = de;
    hsync_in = 1'($urandom_range(0, 1)); vsync_in = 1'($urandom_range(0, 1));
    base = 0;
`ifdef PRIDE_SCROLL_EN
    base = (frame_idx / SF) % nstr[frame_flag];
`endif
    cur = 6'h00;
    if (de) begin
      s = (base + v / hgt[frame_flag]) % nstr[frame_flag];
      cur = pal[frame_flag][s];
    end
    fe = (h == HD) && (v == VD - 1);
    if (fe) begin
      if (int'(flag_sel) != frame_flag) frame_idx = 0; else frame_idx++;
      frame_flag = int'(flag_sel);
    end
    @(negedge clk);
    if ({r, g, b} !== s1_rgb) begin
      bad_rgb++; last_v = s1_v; last_got = {r, g, b}; last_want = s1_rgb;
    end
    if (hsync_out !== s1_hs || vsync_out !== s1_vs) bad_sync++;
    if (frame_tick !== fe) bad_ft++;
    if (frame_tick === 1'b1) ft_seen++;
    if (s1_de) obs[s1_v] = {r, g, b};
    else if ({r, g, b} !== 6'h00) blank_nz++;
    s1_rgb = cur; s1_hs = hsync_in; s1_vs = vsync_in; s1_de = de; s1_v = v;
  endtask

  task automatic run_line(input int v);
    tick($urandom_range(0, HD - 1), v);
    tick($urandom_range(0, HD - 1), v);
    tick(HD, v);
    tick($urandom_range(HD + 1, HT - 1), v);
  endtask

  task automatic run_frame();
    for (int v = 0; v < VT; v++) run_line(v);
  endtask

  task automatic test_reset();
    reset = 1'b1; hpos = 10'(HD); vpos = 10'(VD - 1); display_on = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; flag_sel = 2'd3;
    @(negedge clk); @(negedge clk);
    n_checks++; if ({r, g, b} !== 6'h00) begin n_fail++; $display("FAIL reset_rgb: got %h want 00", {r, g, b}); end
    n_checks++; if (hsync_out !== 1'b0 || vsync_out !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %b%b want 00", hsync_out, vsync_out); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    hpos = '0; vpos = '0; display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; flag_sel = 2'd0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_rainbow();
    clear_stats();
    tick(10, 0);
    n_checks++; if ({r, g, b} !== 6'h00) begin n_fail++; $display("FAIL latency_1clk: got %h want 00", {r, g, b}); end
    tick(11, 0);
    n_checks++; if ({r, g, b} !== 6'h30) begin n_fail++; $display("FAIL latency_2clk: got %h want 30", {r, g, b}); end
    tick(HD, 0); tick(700, 0);
    for (int v = 1; v < VT; v++) run_line(v);
    n_checks++; if (obs[79] !== 6'h30) begin n_fail++; $display("FAIL rainbow_v79: got %h want 30", obs[79]); end
    n_checks++; if (obs[80] !== 6'h34) begin n_fail++; $display("FAIL rainbow_v80: got %h want 34", obs[80]); end
    n_checks++; if (obs[479] !== 6'h22) begin n_fail++; $display("FAIL rainbow_v479: got %h want 22", obs[479]); end
    n_checks++; if (bad_rgb !== 0) begin n_fail++; $display("FAIL rainbow_pixels: %0d bad, v=%0d got %h want %h", bad_rgb, last_v, last_got, last_want); end
    n_checks++; if (bad_sync !== 0) begin n_fail++; $display("FAIL rainbow_sync: %0d bad want 0", bad_sync); end
    n_checks++; if (ft_seen !== 1 || bad_ft !== 0) begin n_fail++; $display("FAIL rainbow_tick: seen %0d bad %0d want 1/0", ft_seen, bad_ft); end
  endtask

  task automatic test_flag_change();
    clear_stats();
    for (int v = 0; v < VT; v++) begin
      if (v == 200) flag_sel = 2'd1;
      run_line(v);
    end
    n_checks++; if (obs[200] !== 6'h3C) begin n_fail++; $display("FAIL midframe_still_rainbow: got %h want 3c", obs[200]); end
    run_frame();
    n_checks++; if (obs[95] !== 6'h1B) begin n_fail++; $display("FAIL trans_v95: got %h want 1b", obs[95]); end
    n_checks++; if (obs[96] !== 6'h3A) begin n_fail++; $display("FAIL trans_v96: got %h want 3a", obs[96]); end
    n_checks++; if (obs[200] !== 6'h3F) begin n_fail++; $display("FAIL trans_v200: got %h want 3f", obs[200]); end
    n_checks++; if (bad_rgb !== 0) begin n_fail++; $display("FAIL flag_pixels: %0d bad, v=%0d got %h want %h", bad_rgb, last_v, last_got, last_want); end
    n_checks++; if (ft_seen !== 2 || bad_ft !== 0) begin n_fail++; $display("FAIL flag_tick: seen %0d bad %0d want 2/0", ft_seen, bad_ft); end
  endtask

  task automatic test_nonbinary();
    flag_sel = 2'd3;
    run_frame();
    clear_stats();
    run_frame();
    n_checks++; if (obs[0] !== 6'h3C) begin n_fail++; $display("FAIL nb_v0: got %h want 3c", obs[0]); end
    n_checks++; if (obs[360] !== 6'h00) begin n_fail++; $display("FAIL nb_v360: got %h want 00", obs[360]); end
    n_checks++; if (obs[479] !== 6'h00) begin n_fail++; $display("FAIL nb_v479: got %h want 00", obs[479]); end
    n_checks++; if (blank_nz !== 0) begin n_fail++; $display("FAIL nb_blank: %0d nonzero blank pixels want 0", blank_nz); end
    n_checks++; if (bad_rgb !== 0 || bad_sync !== 0) begin n_fail++; $display("FAIL nb_pixels: rgb %0d sync %0d bad want 0", bad_rgb, bad_sync); end
  endtask

  task automatic test_random_flags();
    clear_stats();
    for (int f = 0; f < 3; f++)
      for (int v = 0; v < VT; v++) begin
        flag_sel = 2'($urandom_range(0, 3));
        run_line(v);
      end
    n_checks++; if (bad_rgb !== 0) begin n_fail++; $display("FAIL random_pixels: %0d bad, v=%0d got %h want %h", bad_rgb, last_v, last_got, last_want); end
    n_checks++; if (bad_sync !== 0) begin n_fail++; $display("FAIL random_sync: %0d bad want 0", bad_sync); end
    n_checks++; if (ft_seen !== 3 || bad_ft !== 0) begin n_fail++; $display("FAIL random_tick: seen %0d bad %0d want 3/0", ft_seen, bad_ft); end
  endtask

  task automatic test_reset_midline();
    flag_sel = 2'd2;
    run_frame();
    for (int v = 0; v < 300; v++) run_line(v);
    hsync_in = 1'b1;
    tick(320, 300); tick(320, 300);
    n_checks++; if ({r, g, b} !== 6'h02) begin n_fail++; $display("FAIL bi_v300: got %h want 02", {r, g, b}); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({r, g, b, hsync_out, vsync_out, frame_tick} !== 9'h0) begin n_fail++; $display("FAIL async_reset: got %h want 000", {r, g, b, hsync_out, vsync_out, frame_tick}); end
    @(negedge clk);
    hpos = '0; vpos = '0; display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    clear_stats();
    run_frame();
    n_checks++; if (obs[0] !== 6'h30) begin n_fail++; $display("FAIL post_reset_v0: got %h want 30", obs[0]); end
    n_checks++; if (obs[80] !== 6'h34) begin n_fail++; $display("FAIL post_reset_v80: got %h want 34", obs[80]); end
    n_checks++; if (obs[479] !== 6'h22) begin n_fail++; $display("FAIL post_reset_v479: got %h want 22", obs[479]); end
    n_checks++; if (bad_rgb !== 0 || bad_ft !== 0) begin n_fail++; $display("FAIL post_reset_pixels: rgb %0d tick %0d bad want 0", bad_rgb, bad_ft); end
  endtask

`ifdef PRIDE_SCROLL_EN
  task automatic test_scroll();
    logic [5:0] starts [14];
    flag_sel = 2'd0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    clear_stats();
    for (int f = 0; f < 14; f++) begin
      run_frame();
      starts[f] = obs[0];
    end
    n_checks++; if (starts[0] !== 6'h30 || starts[1] !== 6'h30) begin n_fail++; $display("FAIL scroll_f01: got %h %h want 30 30", starts[0], starts[1]); end
    n_checks++; if (starts[2] !== 6'h34 || starts[3] !== 6'h34) begin n_fail++; $display("FAIL scroll_f23: got %h %h want 34 34", starts[2], starts[3]); end
    n_checks++; if (starts[12] !== 6'h30 || starts[13] !== 6'h30) begin n_fail++; $display("FAIL scroll_wrap: got %h %h want 30 30", starts[12], starts[13]); end
    flag_sel = 2'd1;
    run_frame();
    run_frame();
    n_checks++; if (obs[0] !== 6'h1B) begin n_fail++; $display("FAIL scroll_flag_reset: got %h want 1b", obs[0]); end
    n_checks++; if (bad_rgb !== 0) begin n_fail++; $display("FAIL scroll_pixels: %0d bad, v=%0d got %h want %h", bad_rgb, last_v, last_got, last_want); end
  endtask
`endif

  initial begin
    pal[0] = '{c(3,0,0), c(3,1,0), c(3,3,0), c(0,2,0), c(0,0,3), c(2,0,2)};
    pal[1] = '{c(1,2,3), c(3,2,2), c(3,3,3), c(3,2,2), c(1,2,3), c(0,0,0)};
    pal[2] = '{c(3,0,1), c(3,0,1), c(2,0,2), c(0,0,2), c(0,0,2), c(0,0,0)};
    pal[3] = '{c(3,3,0), c(3,3,3), c(2,1,3), c(0,0,0), c(0,0,0), c(0,0,0)};
    nstr = '{6, 5, 5, 4};
    hgt  = '{VD / 6, VD / 5, VD / 5, VD / 4};
    model_reset();
    clear_stats();
    test_reset();
    test_rainbow();
    test_flag_change();
    test_nonbinary();
    test_random_flags();
    test_reset_midline();
`ifdef PRIDE_SCROLL_EN
    test_scroll();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
